// File: rtl/md_ctrl.sv
// Multiply/divide unit with HI/LO registers and a busy/done handshake.
// The operation runs for a fixed number of cycles and stalls dependent
// D-stage instructions in the meantime.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;

  // Result is a function of the latched operands only.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'b00: {res_hi, res_lo} = prod_s;
      2'b01: {res_hi, res_lo} = prod_u;
      2'b10: begin
        if (b_q == '0) begin
          res_lo = '1;
          res_hi = a_q;
        end else if (a_q == 32'h8000_0000 && b_q == '1) begin
          res_lo = 32'h8000_0000;
          res_hi = '0;
        end else begin
          res_lo = $signed(a_q) / $signed(b_q);
          res_hi = $signed(a_q) % $signed(b_q);
        end
      end
      default: begin
        if (b_q == '0) begin
          res_lo = '1;
          res_hi = a_q;
        end else begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          state_d = BUSY;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign done  = done_q;
  assign stall = md_use_d & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_use_d = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .mthi(mthi), .mtlo(mtlo),
    .a(a), .b(b), .md_use_d(md_use_d), .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {hi, lo} computed with wide integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (o)
      2'b00: begin sq = sx * sy; return sq; end
      2'b01: begin up = ux * uy; return up; end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        up = ux / uy;
        return {ux % uy, up[31:0]} ;
      end
    endcase
  endfunction

  // Issues one op in the current cycle; returns positioned in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic use_d, input logic pri_mt, input logic busy_mt);
    logic [63:0] r;
    int unsigned n;
    n = o[1] ? 10 : 5;
    r = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y; md_use_d = use_d;
    mthi = pri_mt; mtlo = pri_mt;
    #1 check("stall_start", stall, use_d);
    step();
    start = 1'b0; mthi = busy_mt; mtlo = busy_mt;
    for (int unsigned i = 1; i <= n; i++) begin
      a = $urandom; b = $urandom;
      #1;
      check("busy", busy, 1'b1);
      check("done_in_busy", done, 1'b0);
      check("hi_hold", hi, exp_hi);
      check("lo_hold", lo, exp_lo);
      check("stall_busy", stall, use_d);
      step();
    end
    mthi = 1'b0; mtlo = 1'b0;
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    #1;
    check("busy_end", busy, 1'b0);
    check("done", done, 1'b1);
    check("hi_res", hi, exp_hi);
    check("lo_res", lo, exp_lo);
    check("stall_done", stall, 1'b0);
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] v);
    mthi = h; mtlo = l; a = v;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) exp_hi = v;
    if (l) exp_lo = v;
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
  endtask

  task automatic reset_in_cycle3();
    start = 1'b1; op = 2'b00; a = 32'h1111_2222; b = 32'h3333_4444;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int unsigned sel;

    #2 reset = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    step();
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    check("mult_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_lo_k", lo, 32'hFFFF_FFFE);
    step();
    check("done_one_cycle", done, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    check("multu_hi_k", hi, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    check("div_lo_k", lo, 32'hFFFF_FFFD);
    check("div_hi_k", hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    check("divu_lo_k", lo, 32'd14);
    check("divu_hi_k", hi, 32'd2);
    run_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b0);
    check("div0_lo_k", lo, 32'hFFFF_FFFF);
    check("div0_hi_k", hi, 32'hDEAD_BEEF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("ovf_lo_k", lo, 32'h8000_0000);
    check("ovf_hi_k", hi, 32'h0);
    step();
    run_op(2'b10, 32'd1000, 32'd3, 1'b1, 1'b1, 1'b1);
    step();
    md_use_d = 1'b0;

    mt(1'b1, 1'b0, 32'hA5A5_0001);
    mt(1'b0, 1'b1, 32'h5A5A_0002);
    mt(1'b1, 1'b1, 32'hC0DE_0003);

    reset_in_cycle3();
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      check("no_done_after_rst", done, 1'b0);
      check("idle_after_rst", busy, 1'b0);
    end
    reset_in_cycle3();
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    step();

    for (int unsigned i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 20));
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        md_use_d = 1'b0;
        step();
        check("done_clear", done, 1'b0);
        if ($urandom_range(0, 1) == 1)
          mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
